bus_mastership_ctrl: RTL and testbench

- Acquires 68000 bus mastership on the Amiga bus before PiStorm16 drives any bus cycle, using the BR/BG/BGACK three-wire protocol.
- Shares the acquired bus between two internal requesters with round-robin grant: requester 0 is the Pi access state machine, requester 1 is a future DMA/refresh engine.
- Releases the bus after an idle timeout and aborts if the CPU never grants.
- Sits between the Pi interface/access state machine and the nBR_OE/nBGACK_OE pad drivers.

---
 rtl/bus_mastership_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_mastership_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mastership_ctrl.sv
// Bus mastership controller for PiStorm16.
//
// Acquires 68000 bus mastership on the Amiga bus with the BR/BG/BGACK
// three-wire handshake before any PiStorm16 bus cycle runs. The owned bus is
// then shared round-robin between two internal requesters:
//   requester 0 : Pi access state machine
//   requester 1 : DMA/refresh engine
// Mastership is handed back after IDLE_HOLD strobes with no request, and the
// acquisition is aborted if the CPU has not granted within BG_TIMEOUT strobes.
//
// Ports:
//   sys_clk        system clock (PLL, 140 MHz)
//   nRST           asynchronous active-low reset
//   mc_clk_falling one-sys_clk strobe per CLK_7M falling edge; the bus-side
//                  inputs below are evaluated only while it is high
//   bg_n_sync      synchronized nBG_IN
//   as_n_sync      synchronized nAS
//   dtack_n_sync   synchronized nDTACK
//   bgack_n_sync   synchronized nBGACK_IN
//   req[1:0]       level requests, held until the requester is done
//   done[1:0]      one-cycle pulse, requester finished its cycle
//   gnt[1:0]       one-hot grant; a requester may run only while its bit is set
//   br_oe          drive nBR low
//   bgack_oe       drive nBGACK low
//   is_master      bus owned (OWN or GRANT)
//   bg_timeout     sticky abort flag, cleared by clr_err (set has priority)
//   clr_err        clear bg_timeout
module bus_mastership_ctrl #(
  parameter int unsigned IDLE_HOLD  = 16,
  parameter int unsigned BG_TIMEOUT = 255
) (
  input  logic       sys_clk,
  input  logic       nRST,
  input  logic       mc_clk_falling,
  input  logic       bg_n_sync,
  input  logic       as_n_sync,
  input  logic       dtack_n_sync,
  input  logic       bgack_n_sync,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] gnt,
  output logic       br_oe,
  output logic       bgack_oe,
  output logic       is_master,
  output logic       bg_timeout,
  input  logic       clr_err
);

  // One counter serves both the BG timeout and the idle-hold timer; it is
  // sized for the larger of the two limits.
  localparam int unsigned CntMax = (BG_TIMEOUT > IDLE_HOLD) ? BG_TIMEOUT : IDLE_HOLD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitBus,
    StOwn,
    StGrant,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic              br_oe_q, br_oe_d;
  logic              bgack_oe_q, bgack_oe_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              bg_timeout_q, bg_timeout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CntW-1:0]   cnt_inc;
  logic              bg_expired;
  logic              hold_expired;
  logic              bus_idle;
  logic              abort;
  logic              win_idx;

  assign cnt_inc      = cnt_q + 1'b1;
  assign bg_expired   = (cnt_inc == CntW'(BG_TIMEOUT));
  assign hold_expired = (cnt_inc == CntW'(IDLE_HOLD));
  // The previous master has let go only when AS, DTACK and BGACK are all negated.
  assign bus_idle     = as_n_sync & dtack_n_sync & bgack_n_sync;

  // Round-robin: the requester that was not served last wins if it asks,
  // otherwise the one that was served last.
  always_comb begin
    win_idx = last_q;
    if (req[~last_q]) begin
      win_idx = ~last_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    br_oe_d    = br_oe_q;
    bgack_oe_d = bgack_oe_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    abort      = 1'b0;

    unique case (state_q)
      StIdle: begin
        br_oe_d    = 1'b0;
        bgack_oe_d = 1'b0;
        gnt_d      = 2'b00;
        // A pending abort blocks new acquisitions until software clears it.
        if ((|req) && !bg_timeout_q) begin
          state_d = StReq;
          br_oe_d = 1'b1;
          cnt_d   = '0;
        end
      end

      StReq: begin
        if (mc_clk_falling) begin
          cnt_d = cnt_inc;
          if (!bg_n_sync) begin
            state_d = StWaitBus;
          end else if (bg_expired) begin
            abort = 1'b1;
          end
        end
      end

      StWaitBus: begin
        if (mc_clk_falling) begin
          if (bus_idle) begin
            // BGACK takes over from BR on the same edge, so the two never overlap.
            state_d    = StOwn;
            br_oe_d    = 1'b0;
            bgack_oe_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
            if (bg_expired) begin
              abort = 1'b1;
            end
          end
        end
      end

      StOwn: begin
        if (|req) begin
          state_d = StGrant;
          gnt_d   = win_idx ? 2'b10 : 2'b01;
          cnt_d   = '0;
        end else if (mc_clk_falling) begin
          cnt_d = cnt_inc;
          if (hold_expired) begin
            state_d    = StRelease;
            bgack_oe_d = 1'b0;
            cnt_d      = '0;
          end
        end
      end

      StGrant: begin
        // Only the granted requester's done ends the grant; a dropped req
        // without done keeps the grant alive.
        if (|(done & gnt_q)) begin
          state_d = StOwn;
          last_d  = gnt_q[1];
          gnt_d   = 2'b00;
          cnt_d   = '0;
        end
      end

      StRelease: begin
        // One strobe for the bus hand-back before BR may be raised again.
        if (mc_clk_falling) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d    = StIdle;
        br_oe_d    = 1'b0;
        bgack_oe_d = 1'b0;
        gnt_d      = 2'b00;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      br_oe_d = 1'b0;
    end
  end

  // Setting the abort flag takes priority over a simultaneous clear.
  always_comb begin
    bg_timeout_d = bg_timeout_q;
    if (abort) begin
      bg_timeout_d = 1'b1;
    end else if (clr_err) begin
      bg_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      br_oe_q      <= 1'b0;
      bgack_oe_q   <= 1'b0;
      gnt_q        <= 2'b00;
      last_q       <= 1'b1;
      bg_timeout_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      br_oe_q      <= br_oe_d;
      bgack_oe_q   <= bgack_oe_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      bg_timeout_q <= bg_timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign br_oe      = br_oe_q;
  assign bgack_oe   = bgack_oe_q;
  assign bg_timeout = bg_timeout_q;
  assign is_master  = (state_q == StOwn) || (state_q == StGrant);

endmodule

// File: tb/tb_bus_mastership_ctrl.sv
module tb_bus_mastership_ctrl;

  localparam int IdleHold  = 16;
  localparam int BgTimeout = 255;

  logic       sys_clk = 1'b0;
  logic       nRST = 1'b0;
  logic       mc_clk_falling = 1'b0;
  logic       bg_n_sync = 1'b1;
  logic       as_n_sync = 1'b1;
  logic       dtack_n_sync = 1'b1;
  logic       bgack_n_sync = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [1:0] gnt;
  logic       br_oe;
  logic       bgack_oe;
  logic       is_master;
  logic       bg_timeout;
  logic       clr_err = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  bus_mastership_ctrl #(
    .IDLE_HOLD (IdleHold),
    .BG_TIMEOUT(BgTimeout)
  ) dut (
    .sys_clk       (sys_clk),
    .nRST          (nRST),
    .mc_clk_falling(mc_clk_falling),
    .bg_n_sync     (bg_n_sync),
    .as_n_sync     (as_n_sync),
    .dtack_n_sync  (dtack_n_sync),
    .bgack_n_sync  (bgack_n_sync),
    .req           (req),
    .done          (done),
    .gnt           (gnt),
    .br_oe         (br_oe),
    .bgack_oe      (bgack_oe),
    .is_master     (is_master),
    .bg_timeout    (bg_timeout),
    .clr_err       (clr_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: tracks what is physically driven (BR, BGACK), who
  // holds the grant, and a strobe count; the phase follows from those.
  // ---------------------------------------------------------------------
  bit m_br = 0;        // nBR driven
  bit m_bg_seen = 0;   // CPU has granted, waiting for the bus to go idle
  bit m_bgack = 0;     // nBGACK driven (bus owned)
  int m_gnt = -1;      // granted requester, -1 when none
  int m_last = 1;      // requester served most recently
  bit m_rel = 0;       // handing the bus back
  bit m_err = 0;
  int m_cnt = 0;
  bit m_abort;
  int m_other;

  always @(posedge sys_clk or negedge nRST) begin
    if (!nRST) begin
      m_br = 0; m_bg_seen = 0; m_bgack = 0; m_gnt = -1; m_last = 1;
      m_rel = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_abort = 0;
      if (m_rel) begin
        if (mc_clk_falling) m_rel = 0;
      end else if (m_gnt >= 0) begin
        if (done[m_gnt]) begin
          m_last = m_gnt;
          m_gnt = -1;
          m_cnt = 0;
        end
      end else if (m_bgack) begin
        if (req != 2'b00) begin
          m_other = 1 - m_last;
          m_gnt = req[m_other] ? m_other : m_last;
          m_cnt = 0;
        end else if (mc_clk_falling) begin
          m_cnt++;
          if (m_cnt == IdleHold) begin
            m_bgack = 0;
            m_rel = 1;
            m_cnt = 0;
          end
        end
      end else if (m_br) begin
        if (mc_clk_falling) begin
          if (!m_bg_seen) begin
            m_cnt++;
            if (!bg_n_sync) m_bg_seen = 1;
            else if (m_cnt == BgTimeout) m_abort = 1;
          end else if (as_n_sync && dtack_n_sync && bgack_n_sync) begin
            m_br = 0;
            m_bg_seen = 0;
            m_bgack = 1;
            m_cnt = 0;
          end else begin
            m_cnt++;
            if (m_cnt == BgTimeout) m_abort = 1;
          end
        end
      end else begin
        if (req != 2'b00 && !m_err) begin
          m_br = 1;
          m_bg_seen = 0;
          m_cnt = 0;
        end
      end
      if (m_abort) begin
        m_br = 0;
        m_bg_seen = 0;
        m_err = 1;
      end else if (clr_err) begin
        m_err = 0;
      end
    end
  end

  function automatic logic [1:0] exp_gnt();
    if (m_gnt < 0) return 2'b00;
    return (m_gnt == 0) ? 2'b01 : 2'b10;
  endfunction

  // Every cycle out of reset the outputs must match the model.
  always @(negedge sys_clk) begin
    if (nRST) begin
      chk("m_gnt", gnt, exp_gnt());
      chk("m_br_oe", {1'b0, br_oe}, {1'b0, m_br});
      chk("m_bgack_oe", {1'b0, bgack_oe}, {1'b0, m_bgack});
      chk("m_is_master", {1'b0, is_master}, {1'b0, m_bgack});
      chk("m_bg_timeout", {1'b0, bg_timeout}, {1'b0, m_err});
      chk("inv_gnt_needs_bgack", {1'b0, (gnt != 2'b00) && !bgack_oe}, 2'b00);
      chk("inv_br_bgack_overlap", {1'b0, br_oe && bgack_oe}, 2'b00);
    end
  end

  // Inputs change just after a falling edge and stay stable across the rising edge.
  task automatic cyc(input bit s);
    mc_clk_falling = s;
    @(negedge sys_clk);
    mc_clk_falling = 1'b0;
  endtask

  task automatic strobe();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  logic [1:0] rr_exp [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_br", {1'b0, br_oe}, 2'b00);
    chk("rst_bgack", {1'b0, bgack_oe}, 2'b00);
    chk("rst_master", {1'b0, is_master}, 2'b00);
    chk("rst_err", {1'b0, bg_timeout}, 2'b00);
    nRST = 1'b1;
    cyc(1'b0);

    // Acquisition: BG low on the 3rd strobe, bus idle on the 4th
    req = 2'b01;
    cyc(1'b0);
    chk("acq_br_up", {1'b0, br_oe}, 2'b01);
    strobe();
    strobe();
    chk("acq_br_held", {1'b0, br_oe}, 2'b01);
    bg_n_sync = 1'b0;
    strobe();
    chk("acq_wait_bgack", {1'b0, bgack_oe}, 2'b00);
    cyc(1'b1);
    chk("acq_br_drop", {1'b0, br_oe}, 2'b00);
    chk("acq_bgack_up", {1'b0, bgack_oe}, 2'b01);
    chk("acq_no_gnt_yet", gnt, 2'b00);
    bg_n_sync = 1'b1;
    cyc(1'b0);
    chk("acq_gnt01", gnt, 2'b01);
    done = 2'b10;
    cyc(1'b0);
    chk("foreign_done_ignored", gnt, 2'b01);
    done = 2'b00;
    req = 2'b00;
    cyc(1'b0);
    chk("req_drop_ignored", gnt, 2'b01);
    done = 2'b01;
    cyc(1'b0);
    done = 2'b00;
    chk("done_clears_gnt", gnt, 2'b00);

    // Round-robin from a fresh reset with both requesting
    nRST = 1'b0;
    @(negedge sys_clk);
    nRST = 1'b1;
    req = 2'b11;
    cyc(1'b0);
    bg_n_sync = 1'b0;
    strobe();
    cyc(1'b1);
    bg_n_sync = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 8 && gnt == 2'b00; w++) cyc(1'b0);
      chk("rr_seq", gnt, rr_exp[k]);
      done = gnt;
      cyc(1'b0);
      done = 2'b00;
    end
    for (int w = 0; w < 8 && gnt == 2'b00; w++) cyc(1'b0);
    chk("rr_fifth", gnt, 2'b01);

    // Asynchronous reset in the middle of a grant
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 2'b00);
    chk("async_rst_bgack", {1'b0, bgack_oe}, 2'b00);
    chk("async_rst_master", {1'b0, is_master}, 2'b00);
    chk("async_rst_br", {1'b0, br_oe}, 2'b00);
    req = 2'b00;
    @(negedge sys_clk);
    nRST = 1'b1;
    cyc(1'b0);

    // Bus busy after BG: AS, then DTACK, then BGACK held off
    req = 2'b01;
    cyc(1'b0);
    bg_n_sync = 1'b0;
    as_n_sync = 1'b0;
    strobe();
    for (int k = 0; k < 5; k++) begin
      strobe();
      chk("busy_as", {1'b0, bgack_oe}, 2'b00);
    end
    as_n_sync = 1'b1;
    dtack_n_sync = 1'b0;
    strobe();
    chk("busy_dtack", {1'b0, bgack_oe}, 2'b00);
    dtack_n_sync = 1'b1;
    bgack_n_sync = 1'b0;
    strobe();
    chk("busy_bgack", {1'b0, bgack_oe}, 2'b00);
    bgack_n_sync = 1'b1;
    cyc(1'b1);
    chk("busy_then_owned", {1'b0, bgack_oe}, 2'b01);
    bg_n_sync = 1'b1;
    cyc(1'b0);
    done = 2'b01;
    req = 2'b00;
    cyc(1'b0);
    done = 2'b00;

    // Idle hold: req at strobe 10 restarts the count
    repeat (9) strobe();
    chk("hold_9", {1'b0, is_master}, 2'b01);
    req = 2'b01;
    cyc(1'b0);
    done = 2'b01;
    req = 2'b00;
    cyc(1'b0);
    done = 2'b00;
    repeat (15) strobe();
    chk("hold_restart_15", {1'b0, bgack_oe}, 2'b01);
    strobe();
    chk("hold_16_bgack", {1'b0, bgack_oe}, 2'b00);
    chk("hold_16_master", {1'b0, is_master}, 2'b00);
    // req during release: release completes first
    req = 2'b01;
    cyc(1'b0);
    chk("rel_req_no_br", {1'b0, br_oe}, 2'b00);
    cyc(1'b1);
    cyc(1'b0);
    chk("rel_then_req", {1'b0, br_oe}, 2'b01);

    // BG never arrives
    repeat (BgTimeout - 1) strobe();
    chk("to_254_br", {1'b0, br_oe}, 2'b01);
    chk("to_254_err", {1'b0, bg_timeout}, 2'b00);
    strobe();
    chk("to_255_br", {1'b0, br_oe}, 2'b00);
    chk("to_255_err", {1'b0, bg_timeout}, 2'b01);
    repeat (4) cyc(1'b0);
    chk("err_blocks_req", {1'b0, br_oe}, 2'b00);
    clr_err = 1'b1;
    cyc(1'b0);
    clr_err = 1'b0;
    chk("clr_err", {1'b0, bg_timeout}, 2'b00);
    cyc(1'b0);
    chk("retry_after_clr", {1'b0, br_oe}, 2'b01);

    // Abort coinciding with clr_err: set wins
    clr_err = 1'b1;
    repeat (BgTimeout - 1) strobe();
    cyc(1'b1);
    chk("set_wins", {1'b0, bg_timeout}, 2'b01);
    req = 2'b00;
    cyc(1'b0);
    clr_err = 1'b0;
    chk("clr_after_set", {1'b0, bg_timeout}, 2'b00);
    repeat (3) cyc(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
